isp_cfg_sched: RTL and testbench
================================

Name: isp_cfg_sched

Overview:
- Frame-synchronous configuration scheduler for the ISP chain (DPC → BNR → Bayer-to-RGB888) between video_driver and hdmi_tx.
- Takes register writes from a host bridge into shadow registers over a valid/ready handshake.
- On a commit request, copies the shadows to the active outputs only at the next frame start (vsync assertion edge). DPC/BNR parameters therefore never change mid-frame.

Parameters:
BITS, 16, width of dpc_threshold / cfg_data
VS_POL, 1, active level of in_vsync (1 = active-high)
FRAME_CNT_W, 16, width of frame_cnt
DEF_BAYER, 2, reset Bayer pattern (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR)
WDT_CYCLES, 2475000, watchdog limit in pclk cycles (used only with ISP_CFG_WDT_EN)

Ports:
pclk  in  1  pixel clock; sole clock
rst  in  1  asynchronous, active-high reset
in_vsync  in  1  frame sync from video_driver
cfg_valid  in  1  host write strobe
cfg_ready  out  1  scheduler accepts write
cfg_addr  in  3  register index
cfg_data  in  BITS  write data
cfg_commit  in  1  request frame-aligned apply of shadows
cfg_pending  out  1  commit armed, waiting for frame start
cfg_applied  out  1  one-cycle pulse after active update
cfg_err  out  1  one-cycle pulse on write to unmapped address
dpc_threshold  out  BITS  active DPC threshold
bnr_nr_level  out  3  active BNR level, 0..4
bayer_pattern  out  2  active Bayer pattern
dpc_bypass  out  1  active DPC bypass
bnr_bypass  out  1  active BNR bypass
frame_cnt  out  FRAME_CNT_W  frame-start counter

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - Shadows and actives reset to: threshold 0, nr_level 0, bayer DEF_BAYER, bypasses 0.
  - frame_cnt=0; cfg_pending=0; cfg_applied=0; cfg_err=0.
  - vs_d set to the inactive level. cfg_ready=0 while rst is high, 1 from the first cycle after release.
- Frame start:
  - fs = (in_vsync==VS_POL) && (vs_d!=VS_POL), where vs_d is in_vsync registered once.
  - frame_cnt increments on every fs in all states and wraps to 0 at all-ones.
- Register map (a write is an accepted beat, cfg_valid && cfg_ready):
  - 0: threshold ← cfg_data.
  - 1: nr_level ← min(cfg_data[2:0], 4), saturating.
  - 2: bayer ← cfg_data[1:0].
  - 3: {bnr_bypass, dpc_bypass} ← cfg_data[1:0].
  - 4..7: data dropped, cfg_err pulses on the next cycle.
- FSM states:
  - IDLE: cfg_ready=1, writes update shadows. cfg_commit=1 → ARMED. A write and a commit in the same cycle are both taken, and the write is included in the commit.
  - ARMED: cfg_ready=0, cfg_pending=1. cfg_commit is ignored and cfg_valid is back-pressured. On fs, all actives load the shadows at that clock edge → APPLY.
  - APPLY: one cycle. cfg_applied=1, cfg_ready=0, cfg_pending=0 → IDLE.
- Latency:
  - fs is detected in cycle N. Actives change at the end of cycle N and are visible in N+1.
  - cfg_applied is high in N+1; cfg_ready returns in N+2.
- Other rules:
  - Commit arriving in the same cycle as fs while in IDLE does not apply on that fs; it waits for the next frame.
  - Shadows persist after apply; writes after apply are not visible until the next commit.
  - Mid-operation reset discards pending shadows.

Optional Feature:
- Macro ISP_CFG_WDT_EN.
- With the macro defined:
  - A counter clears on entry to ARMED and increments each ARMED cycle.
  - On reaching WDT_CYCLES with no fs, the actives load anyway (forced apply) → APPLY, and sticky output cfg_wdt (1 bit) sets.
  - cfg_wdt clears only on reset.
- Without the macro: no counter, no cfg_wdt port, and ARMED waits indefinitely.

Decomposition:
- Package isp_cfg_pkg holds:
  - FSM state encoding (IDLE=0, ARMED=1, APPLY=2).
  - Register address constants ADDR_THR, ADDR_NR, ADDR_BAYER, ADDR_BYP.
  - NR_MAX=4 and Bayer pattern codes.
- One sub-module, isp_vs_edge: vsync polarity normalisation, the vs_d register, and the fs pulse.

Test Plan:
- Reset release → bayer_pattern=2, dpc_threshold=0, bnr_nr_level=0, frame_cnt=0, cfg_ready=1 one cycle later.
- Write addr0=0x0040, addr1=7, commit mid-frame → actives unchanged until fs; cycle after fs: dpc_threshold=0x0040, bnr_nr_level=4, cfg_applied single pulse.
- cfg_valid held during ARMED → cfg_ready=0, no shadow change, write completes 2 cycles after fs.
- Write addr5 → cfg_err pulse one cycle later, all shadows unchanged.
- Commit and fs in the same IDLE cycle → apply occurs on the following fs only; frame_cnt increments on both.
- ISP_CFG_WDT_EN, WDT_CYCLES=100, vsync held inactive → forced apply after 100 ARMED cycles, cfg_wdt=1.

Source files
------------

// File: rtl/isp_cfg_pkg.sv
// ---------------------------------------------------------------------------
// isp_cfg_pkg : shared state encoding, register map and helpers for isp_cfg_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package isp_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_t;

  localparam logic [2:0] ADDR_THR   = 3'd0;
  localparam logic [2:0] ADDR_NR    = 3'd1;
  localparam logic [2:0] ADDR_BAYER = 3'd2;
  localparam logic [2:0] ADDR_BYP   = 3'd3;

  localparam logic [2:0] NR_MAX = 3'd4;

  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

  function automatic logic [2:0] sat_nr(input logic [2:0] v);
    return (v > NR_MAX) ? NR_MAX : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isp_vs_edge.sv
// ---------------------------------------------------------------------------
// isp_vs_edge : registers vsync once and pulses fs on the assertion edge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module isp_vs_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic pclk,
  input  logic rst,
  input  logic in_vsync,
  output logic fs
);

  logic vs_d;

  // Reset to the inactive level so a vsync already asserted at release counts as a frame start.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vs_d <= ~VS_POL;
    else     vs_d <= in_vsync;
  end

  assign fs = (in_vsync == VS_POL) && (vs_d != VS_POL);

endmodule

`default_nettype wire

// File: rtl/isp_cfg_sched.sv
// ---------------------------------------------------------------------------
// isp_cfg_sched : shadowed ISP config registers applied only at frame start.
// Optional watchdog forced-apply enabled by macro ISP_CFG_WDT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module isp_cfg_sched
  import isp_cfg_pkg::*;
#(
  parameter int BITS        = 16,
  parameter bit VS_POL      = 1'b1,
  parameter int FRAME_CNT_W = 16,
  parameter int DEF_BAYER   = 2,
  parameter int WDT_CYCLES  = 2475000
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   in_vsync,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_addr,
  input  logic [BITS-1:0]        cfg_data,
  input  logic                   cfg_commit,
  output logic                   cfg_pending,
  output logic                   cfg_applied,
  output logic                   cfg_err,
  output logic [BITS-1:0]        dpc_threshold,
  output logic [2:0]             bnr_nr_level,
  output logic [1:0]             bayer_pattern,
  output logic                   dpc_bypass,
  output logic                   bnr_bypass,
`ifdef ISP_CFG_WDT_EN
  output logic                   cfg_wdt,
`endif
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  if (DEF_BAYER < 0 || DEF_BAYER > 3 || WDT_CYCLES < 1) begin : g_param_check
    $error("isp_cfg_sched: DEF_BAYER must be 0..3 and WDT_CYCLES >= 1");
  end

  cfg_state_t      state;
  logic            fs;
  logic            wr_en;
  logic [BITS-1:0] sh_thr;
  logic [2:0]      sh_nr;
  logic [1:0]      sh_bayer;
  logic            sh_dpc_byp;
  logic            sh_bnr_byp;
  logic            apply_now;

  isp_vs_edge #(.VS_POL(VS_POL)) u_vs_edge (
    .pclk     (pclk),
    .rst      (rst),
    .in_vsync (in_vsync),
    .fs       (fs)
  );

  assign wr_en = cfg_valid && cfg_ready;

`ifdef ISP_CFG_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_hit;
  assign wdt_hit   = (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  assign apply_now = fs || wdt_hit;
`else
  assign apply_now = fs;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cfg_ready     <= 1'b0;
      cfg_pending   <= 1'b0;
      cfg_applied   <= 1'b0;
      cfg_err       <= 1'b0;
      frame_cnt     <= '0;
      sh_thr        <= '0;
      sh_nr         <= '0;
      sh_bayer      <= 2'(DEF_BAYER);
      sh_dpc_byp    <= 1'b0;
      sh_bnr_byp    <= 1'b0;
      dpc_threshold <= '0;
      bnr_nr_level  <= '0;
      bayer_pattern <= 2'(DEF_BAYER);
      dpc_bypass    <= 1'b0;
      bnr_bypass    <= 1'b0;
`ifdef ISP_CFG_WDT_EN
      wdt_cnt       <= '0;
      cfg_wdt       <= 1'b0;
`endif
    end else begin
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;

      if (fs) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);

      if (wr_en) begin
        case (cfg_addr)
          ADDR_THR:   sh_thr   <= cfg_data;
          ADDR_NR:    sh_nr    <= sat_nr(cfg_data[2:0]);
          ADDR_BAYER: sh_bayer <= cfg_data[1:0];
          ADDR_BYP:   {sh_bnr_byp, sh_dpc_byp} <= cfg_data[1:0];
          default:    cfg_err  <= 1'b1;
        endcase
      end

      // Ready/pending/applied are registered copies of the next state.
      case (state)
        ST_IDLE: begin
          if (cfg_commit) begin
            state       <= ST_ARMED;
            cfg_ready   <= 1'b0;
            cfg_pending <= 1'b1;
`ifdef ISP_CFG_WDT_EN
            wdt_cnt     <= '0;
`endif
          end else begin
            cfg_ready   <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (apply_now) begin
            dpc_threshold <= sh_thr;
            bnr_nr_level  <= sh_nr;
            bayer_pattern <= sh_bayer;
            dpc_bypass    <= sh_dpc_byp;
            bnr_bypass    <= sh_bnr_byp;
            state         <= ST_APPLY;
            cfg_pending   <= 1'b0;
            cfg_applied   <= 1'b1;
`ifdef ISP_CFG_WDT_EN
            if (!fs) cfg_wdt <= 1'b1;
          end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
`endif
          end
        end
        ST_APPLY: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          cfg_ready   <= 1'b0;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_isp_cfg_sched.sv
// ---------------------------------------------------------------------------
// tb_isp_cfg_sched : directed self-checking bench for isp_cfg_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_isp_cfg_sched;

  localparam int BITS = 16;
  localparam int FCW  = 16;
`ifdef ISP_CFG_WDT_EN
  localparam int WDT  = 100;
`else
  localparam int WDT  = 2475000;
`endif

  logic            pclk = 1'b0;
  logic            rst;
  logic            in_vsync;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_addr;
  logic [BITS-1:0] cfg_data;
  logic            cfg_commit;
  logic            cfg_pending;
  logic            cfg_applied;
  logic            cfg_err;
  logic [BITS-1:0] dpc_threshold;
  logic [2:0]      bnr_nr_level;
  logic [1:0]      bayer_pattern;
  logic            dpc_bypass;
  logic            bnr_bypass;
  logic [FCW-1:0]  frame_cnt;
`ifdef ISP_CFG_WDT_EN
  logic            cfg_wdt;
`endif

  int checks   = 0;
  int failures = 0;

  isp_cfg_sched #(
    .BITS(BITS), .VS_POL(1'b1), .FRAME_CNT_W(FCW), .DEF_BAYER(2), .WDT_CYCLES(WDT)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .in_vsync      (in_vsync),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_commit    (cfg_commit),
    .cfg_pending   (cfg_pending),
    .cfg_applied   (cfg_applied),
    .cfg_err       (cfg_err),
    .dpc_threshold (dpc_threshold),
    .bnr_nr_level  (bnr_nr_level),
    .bayer_pattern (bayer_pattern),
    .dpc_bypass    (dpc_bypass),
    .bnr_bypass    (bnr_bypass),
`ifdef ISP_CFG_WDT_EN
    .cfg_wdt       (cfg_wdt),
`endif
    .frame_cnt     (frame_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [BITS-1:0] d);
    chk("wr_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_vsync = 1'b0; cfg_valid = 1'b0; cfg_addr = '0;
    cfg_data = '0; cfg_commit = 1'b0;
    step(3);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    chk("rst_bayer", 32'(bayer_pattern), 32'd2);
    chk("rst_thr", 32'(dpc_threshold), 32'd0);
    chk("rst_nr", 32'(bnr_nr_level), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_byp", 32'({bnr_bypass, dpc_bypass}), 32'd0);
`ifdef ISP_CFG_WDT_EN
    chk("rst_wdt", 32'(cfg_wdt), 32'd0);
`endif
    step(1);
    chk("ready_after_rel", 32'(cfg_ready), 32'd1);

    // Basic commit: actives hold until frame start, nr saturates at 4.
    wr(3'd0, 16'h0040);
    wr(3'd1, 16'h0007);
    commit();
    chk("armed_pending", 32'(cfg_pending), 32'd1);
    chk("armed_ready", 32'(cfg_ready), 32'd0);
    step(3);
    chk("armed_thr_hold", 32'(dpc_threshold), 32'd0);
    chk("armed_nr_hold", 32'(bnr_nr_level), 32'd0);
    in_vsync = 1'b1;
    step(1);
    chk("apply_thr", 32'(dpc_threshold), 32'h40);
    chk("apply_nr_sat", 32'(bnr_nr_level), 32'd4);
    chk("apply_pulse", 32'(cfg_applied), 32'd1);
    chk("apply_ready", 32'(cfg_ready), 32'd0);
    chk("apply_pending", 32'(cfg_pending), 32'd0);
    chk("fcnt1", 32'(frame_cnt), 32'd1);
    step(1);
    chk("apply_pulse_end", 32'(cfg_applied), 32'd0);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    in_vsync = 1'b0;
    step(1);

    // Write held during ARMED is back-pressured until two cycles after fs.
    commit();
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h0055;
    step(2);
    chk("bp_ready", 32'(cfg_ready), 32'd0);
    in_vsync = 1'b1;
    step(1);
    chk("bp_applied", 32'(cfg_applied), 32'd1);
    chk("bp_thr_old", 32'(dpc_threshold), 32'h40);
    chk("bp_ready_n1", 32'(cfg_ready), 32'd0);
    step(1);
    chk("bp_ready_n2", 32'(cfg_ready), 32'd1);
    step(1);
    cfg_valid = 1'b0;
    in_vsync = 1'b0;
    commit();
    in_vsync = 1'b1;
    step(1);
    chk("bp_thr_new", 32'(dpc_threshold), 32'h55);
    chk("fcnt3", 32'(frame_cnt), 32'd3);
    step(1);
    in_vsync = 1'b0;
    step(1);

    // Other registers and an unmapped write.
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'h0003);
    chk("err_quiet", 32'(cfg_err), 32'd0);
    wr(3'd1, 16'h0003);
    wr(3'd5, 16'hFFFF);
    chk("err_pulse", 32'(cfg_err), 32'd1);
    step(1);
    chk("err_pulse_end", 32'(cfg_err), 32'd0);
    commit();
    in_vsync = 1'b1;
    step(1);
    chk("map_thr", 32'(dpc_threshold), 32'h55);
    chk("map_nr", 32'(bnr_nr_level), 32'd3);
    chk("map_bayer", 32'(bayer_pattern), 32'd1);
    chk("map_byp", 32'({bnr_bypass, dpc_bypass}), 32'd3);
    step(1);
    in_vsync = 1'b0;
    step(1);

    // Commit coincident with fs in IDLE waits for the following frame.
    wr(3'd0, 16'h0777);
    in_vsync = 1'b1;
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    chk("cofs_pending", 32'(cfg_pending), 32'd1);
    chk("cofs_fcnt5", 32'(frame_cnt), 32'd5);
    chk("cofs_thr_hold", 32'(dpc_threshold), 32'h55);
    in_vsync = 1'b0;
    step(2);
    chk("cofs_no_apply", 32'(cfg_applied), 32'd0);
    in_vsync = 1'b1;
    step(1);
    chk("cofs_thr", 32'(dpc_threshold), 32'h777);
    chk("cofs_applied", 32'(cfg_applied), 32'd1);
    chk("cofs_fcnt6", 32'(frame_cnt), 32'd6);
    step(1);
    in_vsync = 1'b0;
    step(1);

`ifdef ISP_CFG_WDT_EN
    begin
      int n;
      chk("wdt_clear", 32'(cfg_wdt), 32'd0);
      wr(3'd0, 16'h0ABC);
      commit();
      n = 0;
      while (cfg_applied !== 1'b1 && n < 300) begin
        step(1);
        n++;
      end
      chk("wdt_cycles", 32'(n), 32'd100);
      chk("wdt_flag", 32'(cfg_wdt), 32'd1);
      chk("wdt_thr", 32'(dpc_threshold), 32'hABC);
      chk("wdt_fcnt", 32'(frame_cnt), 32'd6);
      step(2);
      chk("wdt_sticky", 32'(cfg_wdt), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
